// File: rtl/control_sequencer_pkg.sv
// Shared types for the SAP-1 controller-sequencer: opcodes, ring states,
// the packed control word and the ring one-hot helper.
package control_sequencer_pkg;

  localparam int OPCODE_W = 4;
  localparam int T_STATES = 6;

  typedef enum logic [OPCODE_W-1:0] {
    OP_LDA = 4'h0,
    OP_ADD = 4'h1,
    OP_SUB = 4'h2,
    OP_OUT = 4'hE,
    OP_HLT = 4'hF
  } opcode_e;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_T1   = 3'd1,
    ST_T2   = 3'd2,
    ST_T3   = 3'd3,
    ST_T4   = 3'd4,
    ST_T5   = 3'd5,
    ST_T6   = 3'd6,
    ST_HALT = 3'd7
  } tstate_e;

  typedef struct packed {
    logic cp;
    logic ep;
    logic lm;
    logic ce;
    logic li;
    logic ei;
    logic la;
    logic ea;
    logic su;
    logic eu;
    logic lb;
    logic lo;
  } ctrl_word_t;

  // IDLE and HALT have no ring position, so they map to all-zero.
  function automatic logic [T_STATES-1:0] ring_onehot(tstate_e s);
    logic [T_STATES-1:0] v;
    v = '0;
    case (s)
      ST_T1:   v[0] = 1'b1;
      ST_T2:   v[1] = 1'b1;
      ST_T3:   v[2] = 1'b1;
      ST_T4:   v[3] = 1'b1;
      ST_T5:   v[4] = 1'b1;
      ST_T6:   v[5] = 1'b1;
      default: v = '0;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/control_sequencer_if.sv
// Control-sequencer bundle: run/opcode in, control word, ring position and halt flag out.
interface control_sequencer_if;
  import control_sequencer_pkg::*;

  logic                run;
  logic [OPCODE_W-1:0] opcode;
  logic                cp, ep, lm, ce, li, ei, la, ea, su, eu, lb, lo;
  logic [T_STATES-1:0] t_state;
  logic                halted;

  modport master (
    input  run, opcode,
    output cp, ep, lm, ce, li, ei, la, ea, su, eu, lb, lo, t_state, halted
  );

  modport slave (
    output run, opcode,
    input  cp, ep, lm, ce, li, ei, la, ea, su, eu, lb, lo, t_state, halted
  );
endinterface

// File: rtl/control_sequencer_t_state_ring.sv
// T-state ring: IDLE -> T1..T6 loop, gated by run, with HLT capture into a
// sticky HALT state. Advances on the falling clock edge.
module control_sequencer_t_state_ring
  import control_sequencer_pkg::*;
(
  input  logic                clock,
  input  logic                reset,
  input  logic                run,
  input  logic                hlt_decoded,
  output tstate_e             state,
  output logic [T_STATES-1:0] t_state,
  output logic                halted
);

  tstate_e state_reg, state_next;

  // Negedge update lets the decoded controls settle before datapath posedge loads.
  always_ff @(negedge clock or negedge reset) begin
    if (!reset) state_reg <= ST_IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    if (run) begin
      case (state_reg)
        ST_IDLE: state_next = ST_T1;
        ST_T1:   state_next = ST_T2;
        ST_T2:   state_next = ST_T3;
        ST_T3:   state_next = ST_T4;
        ST_T4:   state_next = hlt_decoded ? ST_HALT : ST_T5;
        ST_T5:   state_next = ST_T6;
        ST_T6:   state_next = ST_T1;
        ST_HALT: state_next = ST_HALT;
        default: state_next = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    state   = state_reg;
    t_state = ring_onehot(state_reg);
    halted  = (state_reg == ST_HALT);
  end

endmodule

// File: rtl/control_sequencer.sv
// SAP-1 controller-sequencer top: T-state ring plus microcode decode of
// (state, opcode) into the datapath control word.
module control_sequencer
  import control_sequencer_pkg::*;
(
  input  logic                 clock,
  input  logic                 reset,
  control_sequencer_if.master  bus
);

  tstate_e             state;
  logic [T_STATES-1:0] t_state;
  logic                halted;
  ctrl_word_t          ctrl;
  opcode_e             op;

  assign op = opcode_e'(bus.opcode);

  control_sequencer_t_state_ring u_ring (
    .clock       (clock),
    .reset       (reset),
    .run         (bus.run),
    .hlt_decoded (op == OP_HLT),
    .state       (state),
    .t_state     (t_state),
    .halted      (halted)
  );

  // Pausing forces the whole word low so a held state cannot repeat its loads.
  always_comb begin
    ctrl = '0;
    if (bus.run) begin
      case (state)
        ST_T1: begin ctrl.ep = 1'b1; ctrl.lm = 1'b1; end
        ST_T2: ctrl.cp = 1'b1;
        ST_T3: begin ctrl.ce = 1'b1; ctrl.li = 1'b1; end
        ST_T4: begin
          case (op)
            OP_LDA, OP_ADD, OP_SUB: begin ctrl.ei = 1'b1; ctrl.lm = 1'b1; end
            OP_OUT:                 begin ctrl.ea = 1'b1; ctrl.lo = 1'b1; end
            default:                ctrl = '0;
          endcase
        end
        ST_T5: begin
          case (op)
            OP_LDA:         begin ctrl.ce = 1'b1; ctrl.la = 1'b1; end
            OP_ADD, OP_SUB: begin ctrl.ce = 1'b1; ctrl.lb = 1'b1; end
            default:        ctrl = '0;
          endcase
        end
        ST_T6: begin
          case (op)
            OP_ADD:  begin ctrl.eu = 1'b1; ctrl.la = 1'b1; end
            OP_SUB:  begin ctrl.su = 1'b1; ctrl.eu = 1'b1; ctrl.la = 1'b1; end
            default: ctrl = '0;
          endcase
        end
        default: ctrl = '0;
      endcase
    end
  end

  always_comb begin
    bus.cp      = ctrl.cp;
    bus.ep      = ctrl.ep;
    bus.lm      = ctrl.lm;
    bus.ce      = ctrl.ce;
    bus.li      = ctrl.li;
    bus.ei      = ctrl.ei;
    bus.la      = ctrl.la;
    bus.ea      = ctrl.ea;
    bus.su      = ctrl.su;
    bus.eu      = ctrl.eu;
    bus.lb      = ctrl.lb;
    bus.lo      = ctrl.lo;
    bus.t_state = t_state;
    bus.halted  = halted;
  end

endmodule

// File: tb/tb_control_sequencer.sv
// Self-checking bench for control_sequencer: directed literal steps, then
// randomized run/opcode/reset checked each cycle against a phase-counter model.
module tb_control_sequencer;

  localparam logic [11:0] CP = 12'h800, EP = 12'h400, LM = 12'h200, CE = 12'h100;
  localparam logic [11:0] LI = 12'h080, EI = 12'h040, LA = 12'h020, EA = 12'h010;
  localparam logic [11:0] SU = 12'h008, EU = 12'h004, LB = 12'h002, LO = 12'h001;

  logic clock = 1'b0;
  logic reset;
  int   tests_run = 0;
  int   tests_failed = 0;
  bit   check_en = 1'b0;
  int   ph = 0;  // 0 idle, 1..6 = T1..T6, 7 halted

  control_sequencer_if bus();

  control_sequencer dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  logic [11:0] dut_ctrl;
  assign dut_ctrl = {bus.cp, bus.ep, bus.lm, bus.ce, bus.li, bus.ei,
                     bus.la, bus.ea, bus.su, bus.eu, bus.lb, bus.lo};

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Microcode table: control word for a given step (1..6) of an instruction.
  function automatic logic [11:0] model_ctrl(int p, logic [3:0] op, logic r);
    logic [11:0] w;
    w = '0;
    if (r) begin
      if (p == 1) w = EP | LM;
      else if (p == 2) w = CP;
      else if (p == 3) w = CE | LI;
      else if (p >= 4 && p <= 6) begin
        case (op)
          4'h0: w = (p == 4) ? (EI | LM) : (p == 5) ? (CE | LA) : 12'h000;
          4'h1: w = (p == 4) ? (EI | LM) : (p == 5) ? (CE | LB) : (EU | LA);
          4'h2: w = (p == 4) ? (EI | LM) : (p == 5) ? (CE | LB) : (SU | EU | LA);
          4'hE: w = (p == 4) ? (EA | LO) : 12'h000;
          default: w = 12'h000;
        endcase
      end
    end
    return w;
  endfunction

  function automatic logic [5:0] model_tstate(int p);
    logic [5:0] v;
    v = '0;
    if (p >= 1 && p <= 6) v = 6'(1 << (p - 1));
    return v;
  endfunction

  always @(negedge clock or negedge reset) begin
    if (!reset) ph = 0;
    else if (bus.run) begin
      if (ph == 0) ph = 1;
      else if (ph == 4 && bus.opcode == 4'hF) ph = 7;
      else if (ph >= 1 && ph <= 6) ph = (ph % 6) + 1;
    end
  end

  always @(posedge clock) begin
    if (check_en) begin
      check("cyc_ctrl", {20'd0, dut_ctrl}, {20'd0, model_ctrl(ph, bus.opcode, bus.run)});
      check("cyc_t_state", {26'd0, bus.t_state}, {26'd0, model_tstate(ph)});
      check("cyc_halted", {31'd0, bus.halted}, {31'd0, (ph == 7)});
      check("cyc_onehot", {31'd0, ($countones(bus.t_state) <= 1)}, 32'd1);
      check("cyc_bus_driver",
            {31'd0, ($countones({bus.ep, bus.ce, bus.ei, bus.ea, bus.eu}) <= 1)}, 32'd1);
    end
  end

  task automatic tick(string name, logic [5:0] t, logic [11:0] c);
    @(posedge clock);
    check({name, "_t"}, {26'd0, bus.t_state}, {26'd0, t});
    check({name, "_ctrl"}, {20'd0, dut_ctrl}, {20'd0, c});
    $display("[TB] %s t_state=%b ctrl=%h", name, bus.t_state, dut_ctrl);
  endtask

  initial begin
    logic [3:0] ops [6];
    ops[0] = 4'h0; ops[1] = 4'h1; ops[2] = 4'h2; ops[3] = 4'hE; ops[4] = 4'hF; ops[5] = 4'h7;
    reset = 1'b0; bus.run = 1'b1; bus.opcode = 4'h1;
    repeat (3) @(posedge clock);
    check("rst_t", {26'd0, bus.t_state}, 32'd0);
    check("rst_ctrl", {20'd0, dut_ctrl}, 32'd0);
    check("rst_halted", {31'd0, bus.halted}, 32'd0);
    check_en = 1'b1;
    #1 reset = 1'b1;

    // ADD
    tick("add_t1", 6'b000001, EP | LM);
    tick("add_t2", 6'b000010, CP);
    tick("add_t3", 6'b000100, CE | LI);
    tick("add_t4", 6'b001000, EI | LM);
    tick("add_t5", 6'b010000, CE | LB);
    tick("add_t6", 6'b100000, EU | LA);
    tick("add_wrap", 6'b000001, EP | LM);
    // SUB
    #1 bus.opcode = 4'h2;
    tick("sub_t2", 6'b000010, CP);
    tick("sub_t3", 6'b000100, CE | LI);
    tick("sub_t4", 6'b001000, EI | LM);
    tick("sub_t5", 6'b010000, CE | LB);
    tick("sub_t6", 6'b100000, SU | EU | LA);
    // OUT
    #1 bus.opcode = 4'hE;
    tick("out_t1", 6'b000001, EP | LM);
    tick("out_t2", 6'b000010, CP);
    tick("out_t3", 6'b000100, CE | LI);
    tick("out_t4", 6'b001000, EA | LO);
    tick("out_t5", 6'b010000, 12'h000);
    tick("out_t6", 6'b100000, 12'h000);
    // Pause in T2
    tick("pause_t1", 6'b000001, EP | LM);
    tick("pause_t2", 6'b000010, CP);
    #1 bus.run = 1'b0;
    repeat (5) tick("paused", 6'b000010, 12'h000);
    #1 bus.run = 1'b1;
    tick("resume_t3", 6'b000100, CE | LI);
    // Async reset mid-T5 of LDA
    #1 bus.opcode = 4'h0;
    tick("lda_t4", 6'b001000, EI | LM);
    tick("lda_t5", 6'b010000, CE | LA);
    #2 reset = 1'b0;
    #1;
    check("async_rst_t", {26'd0, bus.t_state}, 32'd0);
    check("async_rst_ctrl", {20'd0, dut_ctrl}, 32'd0);
    @(posedge clock);
    #1 reset = 1'b1;
    tick("restart_t1", 6'b000001, EP | LM);
    // HLT
    #1 bus.opcode = 4'hF;
    tick("hlt_t2", 6'b000010, CP);
    tick("hlt_t3", 6'b000100, CE | LI);
    tick("hlt_t4", 6'b001000, 12'h000);
    tick("halt", 6'b000000, 12'h000);
    check("halt_flag", {31'd0, bus.halted}, 32'd1);
    repeat (20) begin
      @(posedge clock);
      check("halt_hold", {25'd0, bus.halted, bus.t_state}, {25'd0, 7'b1000000});
    end
    #1 reset = 1'b0;
    @(posedge clock);
    check("halt_cleared", {31'd0, bus.halted}, 32'd0);
    #1 reset = 1'b1;

    // Randomized run/opcode/reset, checked per cycle by the compare process.
    for (int i = 0; i < 300; i++) begin
      @(posedge clock);
      #1;
      bus.run    = ($urandom_range(0, 9) != 0);
      bus.opcode = ops[$urandom_range(0, 5)];
      reset      = ($urandom_range(0, 29) != 0);
      $display("[TB] rnd %0d run=%0b op=%h reset=%0b phase=%0d", i, bus.run, bus.opcode, reset, ph);
    end
    @(posedge clock);
    #1;
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
